pkt_in_arbiter: RTL

Packet-granularity round-robin arbiter that merges NUM_PORTS ingress 134-bit packet streams into the single 134-bit packet stream and 8-bit inport feeding the PHV generator / configuration parser. It sits directly in front of that generator. It owns the generator's `i_pkt_valid`/`i_pkt`/`i_inport` inputs. It guarantees three things at that interface: whole packets only, no interleaving, and a configurable idle gap between packets. The downstream block has no backpressure and relies on valid deassertion and head tags, so the arbiter is the only point of flow control.

---
 rtl/pkt_in_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/pkt_in_arbiter.sv
// pkt_in_arbiter: packet-granularity round-robin merge of NUM_PORTS slice streams with a post-tail idle gap.
module pkt_in_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_PORTS-1:0]     i_pkt_valid,
  input  logic [NUM_PORTS*134-1:0] i_pkt,
  output logic [NUM_PORTS-1:0]     o_pkt_ready,
  output logic                     o_pkt_valid,
  output logic [133:0]             o_pkt,
  output logic [7:0]               o_inport,
  output logic                     o_abort,
  output logic                     o_err,
  output logic                     o_busy
);
  localparam int PW = $clog2(NUM_PORTS);
  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;
  state_t state, state_nx;
  logic [PW-1:0] rr_ptr, rr_nx, grant, grant_nx, win, idx;
  logic [7:0] idle_cnt;
  logic [3:0] gap_cnt;
  logic [NUM_PORTS-1:0] head, req, drain;
  logic [133:0] gslice;
  logic found, acc, tmo, gap_done;
  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_head
    assign head[k] = i_pkt[134*k+132];
  end
  assign req      = i_pkt_valid & head;
  assign drain    = i_pkt_valid & ~head;
  assign gslice   = i_pkt[134*int'(grant) +: 134];
  assign acc      = state == XFER && i_pkt_valid[grant];
  // abort fires on the increment that would bring the idle count to TIMEOUT; a same-cycle accept wins
  assign tmo      = state == XFER && !acc && idle_cnt == 8'(TIMEOUT-1);
  assign gap_done = gap_cnt == 4'(GAP_CYCLES-1);
  assign o_busy   = state != IDLE;
  assign o_inport = 8'(grant);
  assign o_pkt_ready = i_rst ? '0 : state == XFER ? NUM_PORTS'(1) << grant : state == IDLE ? drain : '0;
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = NUM_PORTS-1; i >= 0; i--) begin
      idx = PW'((int'(rr_ptr) + i) % NUM_PORTS);
      if (req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    rr_nx    = rr_ptr;
    case (state)
      IDLE: if (found) begin
        state_nx = XFER;
        grant_nx = win;
        rr_nx    = win == PW'(NUM_PORTS-1) ? '0 : win + 1'b1;
      end
      XFER: state_nx = acc && gslice[133] ? (GAP_CYCLES > 0 ? GAP : IDLE) : tmo ? IDLE : XFER;
      GAP:  state_nx = gap_done ? IDLE : GAP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      grant       <= '0;
      rr_ptr      <= '0;
      idle_cnt    <= '0;
      gap_cnt     <= '0;
      o_pkt_valid <= 1'b0;
      o_pkt       <= '0;
      o_abort     <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state       <= state_nx;
      grant       <= grant_nx;
      rr_ptr      <= rr_nx;
      idle_cnt    <= state == XFER && !acc && !tmo ? idle_cnt + 1'b1 : '0;
      gap_cnt     <= state == GAP && !gap_done ? gap_cnt + 1'b1 : '0;
      o_pkt_valid <= acc;
      if (acc) o_pkt <= gslice;
      o_abort     <= tmo;
      o_err       <= state == IDLE && |drain;
    end
  end
endmodule
